// File: rtl/midi_spi_master_if.sv
// midi_spi_master_if
// Bundles the command handshake, the SPI pins and the status outputs of
// midi_spi_master so the block can be wired with a single port.
//   cmd_valid/cmd_ready     : request handshake (host -> block)
//   cmd_note_on/note/velocity: message fields, sampled at the handshake
//   spi_sclk/mosi/nss        : SPI mode-0 outputs of the block
//   spi_miso                 : SPI serial input, synchronous to clk
//   busy/done                : block status, done is a one-cycle pulse
//   rx_byte/rx_valid         : last received byte and its update pulse
// Modports:
//   master : the SPI master block itself
//   slave  : everything around it (host side and SPI peripheral side)
interface midi_spi_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_note_on;
    logic [6:0] cmd_note;
    logic [6:0] cmd_velocity;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_nss;
    logic       spi_miso;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       rx_valid;

    modport master (
        input  cmd_valid, cmd_note_on, cmd_note, cmd_velocity, spi_miso,
        output cmd_ready, spi_sclk, spi_mosi, spi_nss, busy, done,
               rx_byte, rx_valid
    );

    modport slave (
        output cmd_valid, cmd_note_on, cmd_note, cmd_velocity, spi_miso,
        input  cmd_ready, spi_sclk, spi_mosi, spi_nss, busy, done,
               rx_byte, rx_valid
    );
endinterface

// File: rtl/midi_spi_master.sv
// midi_spi_master
// Sends a three-byte MIDI note message (status, note, velocity) over a
// mode-0 SPI link and captures the byte clocked back on spi_miso during
// each transmitted byte.
// Parameters:
//   CLK_DIV  : SCLK half-period in clk cycles (2..255)
//   BYTE_GAP : idle cycles between bytes, NSS low / SCLK low (1..255)
//   NSS_HOLD : minimum NSS-high cycles after a message (1..255)
// Ports:
//   clk   : system clock, all logic on its rising edge
//   reset : synchronous, active-high
//   bus   : midi_spi_master_if.master (handshake, SPI pins, status)
module midi_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int BYTE_GAP = 8,
    parameter int NSS_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    midi_spi_master_if.master      bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP,
        TRAIL,
        HOLD
    } state_t;

    // Terminal counts; every phase counts 0..LAST so no phase ever wraps.
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(BYTE_GAP - 1);
    localparam logic [7:0] HOLD_LAST = 8'(NSS_HOLD - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [1:0] r_byte;
    logic [7:0] r_tx;
    logic [7:0] r_b1;
    logic [7:0] r_b2;
    logic [7:0] r_rx_sh;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_nss;
    logic       r_done;

    logic [7:0] w_b0;
    logic [7:0] w_next_byte;

    assign w_b0        = bus.cmd_note_on ? 8'h90 : 8'h80;
    assign w_next_byte = (r_byte == 2'd0) ? r_b1 : r_b2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_byte     <= 2'd0;
            r_tx       <= 8'd0;
            r_b1       <= 8'd0;
            r_b2       <= 8'd0;
            r_rx_sh    <= 8'd0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_nss      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // All three bytes are captured here so later input
                        // changes cannot corrupt the message in flight.
                        r_state <= LEAD;
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_byte  <= 2'd0;
                        r_tx    <= w_b0;
                        r_b1    <= {1'b0, bus.cmd_note};
                        r_b2    <= {1'b0, bus.cmd_velocity};
                        r_nss   <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_mosi  <= w_b0[7];
                    end
                end
                LEAD: begin
                    if (r_cnt == DIV_LAST) begin
                        r_state <= SHIFT;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (r_cnt != DIV_LAST) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt <= 8'd0;
                        if (!r_sclk) begin
                            // Rising SCLK: the peripheral's bit is captured
                            // on the same edge it sees ours.
                            r_sclk  <= 1'b1;
                            r_rx_sh <= {r_rx_sh[6:0], bus.spi_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit != 3'd7) begin
                                r_bit  <= r_bit + 3'd1;
                                r_tx   <= {r_tx[6:0], 1'b0};
                                r_mosi <= r_tx[6];
                            end else begin
                                r_bit      <= 3'd0;
                                r_rx_byte  <= r_rx_sh;
                                r_rx_valid <= 1'b1;
                                if (r_byte == 2'd2) begin
                                    r_state <= TRAIL;
                                    r_mosi  <= 1'b0;
                                end else begin
                                    // MOSI is preset to the next MSB so it
                                    // is settled for the whole gap.
                                    r_state <= GAP;
                                    r_byte  <= r_byte + 2'd1;
                                    r_tx    <= w_next_byte;
                                    r_mosi  <= w_next_byte[7];
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= SHIFT;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                TRAIL: begin
                    if (r_cnt == DIV_LAST) begin
                        r_state <= HOLD;
                        r_cnt   <= 8'd0;
                        r_nss   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_nss   <= 1'b1;
                    r_sclk  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.spi_sclk  = r_sclk;
    assign bus.spi_mosi  = r_mosi;
    assign bus.spi_nss   = r_nss;
    assign bus.done      = r_done;
    assign bus.rx_byte   = r_rx_byte;
    assign bus.rx_valid  = r_rx_valid;

endmodule

// File: tb/tb_midi_spi_master.sv
// tb_midi_spi_master
// Scoreboard bench: stimulus pushes expected MOSI bytes, MISO bytes to drive
// and expected rx bytes into queues; negedge monitors act as SPI slaves,
// decode traffic and compare. Instance A uses default parameters, instance B
// uses CLK_DIV=2, BYTE_GAP=1, NSS_HOLD=1.
module tb_midi_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    midi_spi_master_if ifa ();
    midi_spi_master_if ifb ();

    midi_spi_master dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa)
    );

    midi_spi_master #(.CLK_DIV(2), .BYTE_GAP(1), .NSS_HOLD(1)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] q_mosi_a[$];
    logic [7:0] q_rx_a[$];
    logic [7:0] q_miso_a[$];
    logic [7:0] q_mosi_b[$];

    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    // ---------------- SPI slave model / monitor for instance A
    bit         a_prev_nss  = 1'b1;
    bit         a_prev_sclk = 1'b0;
    bit         a_prev_mosi = 1'b0;
    bit         a_abort     = 1'b0;
    bit         a_seen_rise = 1'b0;
    int         a_lo_cnt    = 0;
    int         a_hi_cnt    = 0;
    int         a_bits      = 0;
    int         a_byte_idx  = 0;
    int         a_rise_cnt  = 0;
    int         a_viol      = 0;
    int         a_done_cnt  = 0;
    logic [7:0] a_sh        = 8'd0;
    logic [7:0] a_miso_msg[3];

    always @(negedge clk) begin
        if (mon_en) begin
            if (!ifa.spi_nss) begin
                if (a_prev_nss) begin
                    if (a_seen_rise) begin
                        n_cmp++;
                        if (a_hi_cnt < 8) begin
                            n_fail++;
                            $display("FAIL a_nss_hold: got %0d high cycles, expected >= 8", a_hi_cnt);
                        end
                    end
                    a_lo_cnt   = 0;
                    a_bits     = 0;
                    a_byte_idx = 0;
                    a_rise_cnt = 0;
                    a_viol     = 0;
                    a_sh       = 8'd0;
                    for (int i = 0; i < 3; i++)
                        a_miso_msg[i] = (q_miso_a.size() > 0) ? q_miso_a.pop_front() : 8'h00;
                end
                a_lo_cnt++;
                if (!a_prev_sclk && ifa.spi_sclk) begin
                    a_sh = {a_sh[6:0], ifa.spi_mosi};
                    a_bits++;
                    a_rise_cnt++;
                    if (a_bits == 8) begin
                        if (q_mosi_a.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL a_mosi_byte: got 0x%0h, expected no byte", a_sh);
                        end else begin
                            chk("a_mosi_byte", 32'(a_sh), 32'(q_mosi_a.pop_front()));
                        end
                        a_bits = 0;
                        a_byte_idx++;
                    end
                end
                if (a_prev_sclk && ifa.spi_sclk && (ifa.spi_mosi != a_prev_mosi))
                    a_viol++;
            end else if (!a_prev_nss) begin
                if (a_abort) begin
                    chk("a_abort_sclk", 32'(ifa.spi_sclk), 32'd0);
                    chk("a_abort_done", 32'(ifa.done), 32'd0);
                    a_abort     = 1'b0;
                    a_seen_rise = 1'b0;
                end else begin
                    chk("a_nss_low_cycles", a_lo_cnt, 216);
                    chk("a_sclk_rises", a_rise_cnt, 24);
                    chk("a_mosi_change_sclk_high", a_viol, 0);
                    chk("a_done_at_nss_rise", 32'(ifa.done), 32'd1);
                    a_seen_rise = 1'b1;
                end
                a_hi_cnt = 0;
            end
            if (ifa.spi_nss) a_hi_cnt++;
            if (ifa.done) a_done_cnt++;
            if (ifa.rx_valid) begin
                if (q_rx_a.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL a_rx_byte: got 0x%0h, expected no rx_valid", ifa.rx_byte);
                end else begin
                    chk("a_rx_byte", 32'(ifa.rx_byte), 32'(q_rx_a.pop_front()));
                end
            end
            if (!ifa.spi_nss && !ifa.spi_sclk && a_byte_idx < 3)
                ifa.spi_miso = a_miso_msg[a_byte_idx][7 - a_bits];
            a_prev_nss  = ifa.spi_nss;
            a_prev_sclk = ifa.spi_sclk;
            a_prev_mosi = ifa.spi_mosi;
        end
    end

    // ---------------- SPI slave model / monitor for instance B
    bit         b_prev_nss  = 1'b1;
    bit         b_prev_sclk = 1'b0;
    int         b_lo_cnt    = 0;
    int         b_bits      = 0;
    int         b_done_cnt  = 0;
    logic [7:0] b_sh        = 8'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!ifb.spi_nss) begin
                if (b_prev_nss) begin
                    b_lo_cnt = 0;
                    b_bits   = 0;
                end
                b_lo_cnt++;
                if (!b_prev_sclk && ifb.spi_sclk) begin
                    b_sh = {b_sh[6:0], ifb.spi_mosi};
                    b_bits++;
                    if (b_bits == 8) begin
                        if (q_mosi_b.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL b_mosi_byte: got 0x%0h, expected no byte", b_sh);
                        end else begin
                            chk("b_mosi_byte", 32'(b_sh), 32'(q_mosi_b.pop_front()));
                        end
                        b_bits = 0;
                    end
                end
            end else if (!b_prev_nss) begin
                chk("b_nss_low_cycles", b_lo_cnt, 102);
                chk("b_done_at_nss_rise", 32'(ifb.done), 32'd1);
            end
            if (ifb.done) b_done_cnt++;
            b_prev_nss  = ifb.spi_nss;
            b_prev_sclk = ifb.spi_sclk;
        end
    end

    // ---------------- stimulus helpers (instance A)
    task automatic push_a(input bit on, input logic [6:0] note, input logic [6:0] vel,
                          input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2);
        q_mosi_a.push_back(on ? 8'h90 : 8'h80);
        q_mosi_a.push_back({1'b0, note});
        q_mosi_a.push_back({1'b0, vel});
        q_miso_a.push_back(m0);
        q_miso_a.push_back(m1);
        q_miso_a.push_back(m2);
        q_rx_a.push_back(m0);
        q_rx_a.push_back(m1);
        q_rx_a.push_back(m2);
    endtask

    task automatic wait_ready_a(input string name);
        int n = 0;
        while (!ifa.cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ifa.cmd_ready) bound_fail(name);
    endtask

    task automatic drive_a(input bit on, input logic [6:0] note, input logic [6:0] vel);
        ifa.cmd_note_on  = on;
        ifa.cmd_note     = note;
        ifa.cmd_velocity = vel;
    endtask

    // Single request; inputs are scrambled right after the handshake.
    task automatic send_a(input bit on, input logic [6:0] note, input logic [6:0] vel,
                          input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2);
        push_a(on, note, vel, m0, m1, m2);
        drive_a(on, note, vel);
        ifa.cmd_valid = 1'b1;
        wait_ready_a("a_handshake");
        @(posedge clk);
        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        drive_a(1'($urandom), 7'($urandom), 7'($urandom));
    endtask

    initial begin
        ifa.cmd_valid = 1'b0;
        ifa.spi_miso  = 1'b0;
        drive_a(1'b0, 7'd0, 7'd0);
        ifb.cmd_valid    = 1'b0;
        ifb.spi_miso     = 1'b0;
        ifb.cmd_note_on  = 1'b0;
        ifb.cmd_note     = 7'd0;
        ifb.cmd_velocity = 7'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_nss", 32'(ifa.spi_nss), 32'd1);
        chk("rst_sclk", 32'(ifa.spi_sclk), 32'd0);
        chk("rst_mosi", 32'(ifa.spi_mosi), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_rx_valid", 32'(ifa.rx_valid), 32'd0);
        chk("rst_rx_byte", 32'(ifa.rx_byte), 32'd0);
        chk("rst_cmd_ready", 32'(ifa.cmd_ready), 32'd1);
        mon_en = 1'b1;

        // Note on, middle C, velocity 100
        send_a(1'b1, 7'd60, 7'd100, 8'h12, 8'h34, 8'h56);
        chk("a_busy_after_hs", 32'(ifa.busy), 32'd1);
        wait_ready_a("a_msg1_idle");

        // Note off, extreme field values, MISO pattern A5/5A/FF
        send_a(1'b0, 7'h7F, 7'h00, 8'hA5, 8'h5A, 8'hFF);
        wait_ready_a("a_msg2_idle");

        // cmd_valid held across two messages
        push_a(1'b1, 7'h01, 7'h7F, 8'hFF, 8'h00, 8'h81);
        push_a(1'b0, 7'h40, 7'h40, 8'h7E, 8'h3C, 8'hC3);
        drive_a(1'b1, 7'h01, 7'h7F);
        ifa.cmd_valid = 1'b1;
        wait_ready_a("a_held_hs1");
        @(posedge clk);
        @(negedge clk);
        drive_a(1'b0, 7'h40, 7'h40);
        wait_ready_a("a_held_hs2");
        @(posedge clk);
        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        wait_ready_a("a_held_idle");

        // Reset during bit 3 of the note byte
        push_a(1'b1, 7'h22, 7'h33, 8'h0F, 8'hF0, 8'hAA);
        drive_a(1'b1, 7'h22, 7'h33);
        ifa.cmd_valid = 1'b1;
        wait_ready_a("a_abort_hs");
        @(posedge clk);
        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        begin
            int n = 0;
            while (!(a_byte_idx == 1 && a_bits == 3) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) bound_fail("a_abort_point");
        end
        a_abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_nss", 32'(ifa.spi_nss), 32'd1);
        chk("abort_sclk", 32'(ifa.spi_sclk), 32'd0);
        chk("abort_mosi", 32'(ifa.spi_mosi), 32'd0);
        chk("abort_busy", 32'(ifa.busy), 32'd0);
        chk("abort_done", 32'(ifa.done), 32'd0);
        chk("abort_rx_byte", 32'(ifa.rx_byte), 32'd0);
        q_mosi_a.delete();
        q_rx_a.delete();
        q_miso_a.delete();
        // Request raised while reset is still high must not be taken.
        push_a(1'b0, 7'h55, 7'h2A, 8'hC3, 8'h3C, 8'h99);
        drive_a(1'b0, 7'h55, 7'h2A);
        ifa.cmd_valid = 1'b1;
        @(negedge clk);
        chk("rst_priority_nss", 32'(ifa.spi_nss), 32'd1);
        chk("rst_priority_busy", 32'(ifa.busy), 32'd0);
        chk("rst_release_ready", 32'(ifa.cmd_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ifa.cmd_valid = 1'b0;
        chk("post_rst_lead_nss", 32'(ifa.spi_nss), 32'd0);
        wait_ready_a("a_post_rst_idle");

        // Instance B: fastest legal timing
        q_mosi_b.push_back(8'h90);
        q_mosi_b.push_back(8'h15);
        q_mosi_b.push_back(8'h2A);
        ifb.cmd_note_on  = 1'b1;
        ifb.cmd_note     = 7'h15;
        ifb.cmd_velocity = 7'h2A;
        ifb.cmd_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.cmd_valid = 1'b0;
        begin
            int n = 0;
            while (!ifb.cmd_ready && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (!ifb.cmd_ready) bound_fail("b_idle");
        end

        repeat (5) @(negedge clk);
        chk("a_done_count", a_done_cnt, 5);
        chk("b_done_count", b_done_cnt, 1);
        chk("a_mosi_queue_left", q_mosi_a.size(), 0);
        chk("a_rx_queue_left", q_rx_a.size(), 0);
        chk("b_mosi_queue_left", q_mosi_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, expected finish before 50000 cycles");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/midi_spi_master.md
MIDI_SPI_MASTER -- requirements
Module: midi_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal values are 2..255.
REQ-002 Parameter BYTE_GAP, default 8: clk cycles between bytes, with NSS low and SCLK low; legal values are 1..255.
REQ-003 Parameter NSS_HOLD, default 8: minimum clk cycles NSS stays high after a message; legal values are 1..255.
REQ-004 Port clk, input, 1: system clock; everything is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
REQ-006 Port cmd_valid, input, 1: a MIDI message request is present.
REQ-007 Port cmd_ready, output, 1: the block can accept a request.
REQ-008 Port cmd_note_on, input, 1: 1 sends status 0x90, 0 sends status 0x80.
REQ-009 Port cmd_note, input, 7: MIDI note number.
REQ-010 Port cmd_velocity, input, 7: MIDI velocity.
REQ-011 Port spi_sclk, output, 1: SPI clock, mode 0 (idles low).
REQ-012 Port spi_mosi, output, 1: serial data out, MSB first.
REQ-013 Port spi_nss, output, 1: active-low slave select.
REQ-014 Port spi_miso, input, 1: serial data in; treated as synchronous to clk.
REQ-015 Port busy, output, 1: high whenever not IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when a message completes.
REQ-017 Port rx_byte, output, 8: last complete byte shifted in from spi_miso.
REQ-018 Port rx_valid, output, 1: one-cycle pulse when rx_byte updates.

Function
REQ-019 States: IDLE, LEAD, SHIFT, GAP, TRAIL, HOLD; the block shall be in IDLE after reset.
REQ-020 cmd_ready shall equal (state==IDLE); a handshake occurs on a cycle where cmd_valid and cmd_ready are both 1.
REQ-021 On handshake, the block shall latch bytes B0={0x90|0x80}, B1={0,cmd_note}, B2={0,cmd_velocity}; later input changes shall have no effect.
REQ-022 On handshake, the block shall enter LEAD on the next cycle: spi_nss=0, spi_sclk=0, spi_mosi=B0[7]; it stays in LEAD for CLK_DIV cycles, then goes to SHIFT.
REQ-023 SHIFT, per bit: spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; 8 bits per byte; 16*CLK_DIV cycles per byte.
REQ-024 spi_mosi shall change only on the cycle spi_sclk goes high-to-low (the next bit), and on entry to LEAD/GAP; it shall be stable while spi_sclk is high.
REQ-025 spi_miso shall be sampled on the cycle spi_sclk goes low-to-high and shifted in MSB first.
REQ-026 After the 8th bit's high phase, the block shall set rx_byte to the shifted byte and pulse rx_valid for one cycle, on the same cycle sclk returns low.
REQ-027 After B0 and after B1, the block shall enter GAP: BYTE_GAP cycles with spi_sclk=0, spi_nss=0, spi_mosi=next byte bit 7; then return to SHIFT.
REQ-028 After B2, the block shall enter TRAIL: CLK_DIV cycles with spi_nss=0, spi_sclk=0.
REQ-029 On exit from TRAIL: spi_nss=1, done pulses for one cycle, and the block enters HOLD for NSS_HOLD cycles, then IDLE.
REQ-030 NSS low time per message shall be exactly 2*CLK_DIV + 48*CLK_DIV + 2*BYTE_GAP cycles; with defaults this is 216.
REQ-031 cmd_valid shall be ignored outside IDLE; there is no queuing, and a held request is accepted on the first cycle back in IDLE.
REQ-032 Counters shall be wide enough for 255; there shall be no wrap inside a phase.

Reset
REQ-033 Reset in any state, including mid-byte, shall take effect on the next edge: state=IDLE, spi_nss=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rx_valid=0, rx_byte=0x00, cmd_ready=1 the cycle after reset deasserts.
REQ-034 A partially sent message shall be discarded and never resumed; reset takes priority over a simultaneous handshake.

Verification
REQ-035 Defaults, note_on=1, note=60, vel=100 -> slave model decodes 0x90,0x3C,0x64; NSS low for 216 cycles; done pulses once.
REQ-036 note_on=0, note=0x7F, vel=0 -> bytes 0x80,0x7F,0x00; no mosi change while sclk high; 24 rising sclk edges.
REQ-037 miso driven with the pattern 0xA5,0x5A,0xFF -> rx_valid pulses 3 times with rx_byte=0xA5,0x5A,0xFF in order.
REQ-038 cmd_valid held high for two messages -> second handshake at least NSS_HOLD=8 cycles after NSS rises; nothing lost or duplicated.
REQ-039 reset asserted during bit 3 of B1 -> next cycle NSS=1, SCLK=0, no done; a new request then sends a complete, correct message.
REQ-040 CLK_DIV=2, BYTE_GAP=1, NSS_HOLD=1 -> NSS low for 102 cycles; bytes correct.
